// File: rtl/code_verify_fsm.sv
// -----------------------------------------------------------------------------
// code_verify_fsm
// Collects a DIGITS-long code of SYM_W-bit symbols from the input/debounce
// logic, compares it against a reference key latched when the attempt starts,
// and reports the result to the status display. Failed attempts consume a
// try; running out of tries forces a LOCK period before tries are restored.
// An optional inactivity timeout turns a stalled entry into a failed attempt,
// and clear aborts an entry without consuming a try.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   next                start an attempt (only looked at in WAIT)
//   clear               abort entry / acknowledge PASS
//   sym_valid, sym      entered symbol strobe and value (only looked at in ENTRY)
//   key                 reference code, first-entered symbol in the MS slice
//   waiting_for_user    idle, ready for next
//   start_verification  attempt in progress (ENTRY or CHECK)
//   done                code accepted, held until clear
//   fail                single-cycle failed-attempt pulse
//   locked              lockout in progress
//   tries_left          remaining attempts before lockout
//   digit_idx           symbols accepted in the current attempt
// -----------------------------------------------------------------------------
module code_verify_fsm #(
   parameter int SYM_W          = 4,
   parameter int DIGITS         = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCK_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            next,
   input  logic                            clear,
   input  logic                            sym_valid,
   input  logic [SYM_W-1:0]                sym,
   input  logic [DIGITS*SYM_W-1:0]         key,
   output logic                            waiting_for_user,
   output logic                            start_verification,
   output logic                            done,
   output logic                            fail,
   output logic                            locked,
   output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
   output logic [$clog2(DIGITS+1)-1:0]     digit_idx
);

   localparam int TRY_W   = $clog2(MAX_TRIES + 1);
   localparam int DIGIT_W = $clog2(DIGITS + 1);
   localparam int IDLE_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_ENTRY = 3'd1,
      S_CHECK = 3'd2,
      S_PASS  = 3'd3,
      S_FAIL  = 3'd4,
      S_LOCK  = 3'd5
   } state_t;

   state_t                    state_q,    state_d;
   logic [DIGITS*SYM_W-1:0]   key_q,      key_d;
   logic [DIGIT_W-1:0]        digit_idx_q, digit_idx_d;
   logic                      mismatch_q, mismatch_d;
   logic [TRY_W-1:0]          tries_q,    tries_d;
   logic [IDLE_W-1:0]         idle_q,     idle_d;
   logic [LOCK_W-1:0]         lock_q,     lock_d;
   logic [SYM_W-1:0]          cur_sym;

   // Expected symbol for the current position; position 0 is the MS slice.
   always_comb begin
      cur_sym = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_idx_q == DIGIT_W'(i)) begin
            cur_sym = key_q[(DIGITS-1-i)*SYM_W +: SYM_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      digit_idx_d = digit_idx_q;
      mismatch_d  = mismatch_q;
      tries_d     = tries_q;
      idle_d      = idle_q;
      lock_d      = lock_q;

      case (state_q)
         S_WAIT: begin
            if (next) begin
               state_d     = S_ENTRY;
               key_d       = key;
               digit_idx_d = '0;
               mismatch_d  = 1'b0;
               idle_d      = '0;
            end
         end
         S_ENTRY: begin
            if (clear) begin
               state_d = S_WAIT;
            end else if (TIMEOUT_CYCLES != 0 && idle_q >= IDLE_W'(TIMEOUT_CYCLES)) begin
               // Stalled entry is scored as a wrong code.
               state_d    = S_CHECK;
               mismatch_d = 1'b1;
            end else if (sym_valid) begin
               mismatch_d = mismatch_q | (sym != cur_sym);
               idle_d     = '0;
               if (digit_idx_q < DIGIT_W'(DIGITS)) begin
                  digit_idx_d = digit_idx_q + DIGIT_W'(1);
               end
               if (digit_idx_q == DIGIT_W'(DIGITS - 1)) begin
                  state_d = S_CHECK;
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         S_CHECK: begin
            lock_d = '0;
            if (!mismatch_q) begin
               state_d = S_PASS;
            end else if (tries_q <= TRY_W'(1)) begin
               tries_d = '0;
               state_d = S_LOCK;
            end else begin
               tries_d = tries_q - TRY_W'(1);
               state_d = S_FAIL;
            end
         end
         S_PASS: begin
            if (clear) begin
               state_d = S_WAIT;
               tries_d = TRY_W'(MAX_TRIES);
            end
         end
         S_FAIL: begin
            state_d = S_WAIT;
         end
         S_LOCK: begin
            if (lock_q >= LOCK_W'(LOCK_CYCLES - 1)) begin
               state_d = S_WAIT;
               tries_d = TRY_W'(MAX_TRIES);
            end else begin
               lock_d = lock_q + LOCK_W'(1);
            end
         end
         default: begin
            state_d = S_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_WAIT;
         key_q       <= '0;
         digit_idx_q <= '0;
         mismatch_q  <= 1'b0;
         tries_q     <= TRY_W'(MAX_TRIES);
         idle_q      <= '0;
         lock_q      <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         digit_idx_q <= digit_idx_d;
         mismatch_q  <= mismatch_d;
         tries_q     <= tries_d;
         idle_q      <= idle_d;
         lock_q      <= lock_d;
      end
   end

   // Moore outputs straight from registered state.
   assign waiting_for_user   = (state_q == S_WAIT);
   assign start_verification = (state_q == S_ENTRY) || (state_q == S_CHECK);
   assign done               = (state_q == S_PASS);
   assign fail               = (state_q == S_FAIL);
   assign locked             = (state_q == S_LOCK);
   assign tries_left         = tries_q;
   assign digit_idx          = digit_idx_q;

endmodule

// File: tb/tb_code_verify_fsm.sv
module tb_code_verify_fsm;

   logic        clk;
   logic        rst_n;
   logic        next;
   logic        clear;
   logic        sym_valid;
   logic [3:0]  sym;
   logic [15:0] key;
   logic        waiting_for_user;
   logic        start_verification;
   logic        done;
   logic        fail;
   logic        locked;
   logic [1:0]  tries_left;
   logic [2:0]  digit_idx;

   int checks   = 0;
   int failures = 0;
   int n;
   logic seen;

   code_verify_fsm #(
      .SYM_W(4), .DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .next(next), .clear(clear),
      .sym_valid(sym_valid), .sym(sym), .key(key),
      .waiting_for_user(waiting_for_user), .start_verification(start_verification),
      .done(done), .fail(fail), .locked(locked),
      .tries_left(tries_left), .digit_idx(digit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock edge; outputs are looked at 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_attempt(input logic [15:0] k);
      key  = k;
      next = 1'b1;
      step();
      next = 1'b0;
   endtask

   task automatic send_sym(input logic [3:0] s);
      sym       = s;
      sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; next = 1'b0; clear = 1'b0; sym_valid = 1'b0; sym = '0; key = '0;
      #12;
      chk("rst_wait",  waiting_for_user, 1);
      chk("rst_sv",    start_verification, 0);
      chk("rst_done",  done, 0);
      chk("rst_fail",  fail, 0);
      chk("rst_lock",  locked, 0);
      chk("rst_tries", tries_left, 3);
      chk("rst_idx",   digit_idx, 0);
      #4 rst_n = 1'b1;
      step();

      // 1: correct code, PASS, next ignored in PASS, clear back to WAIT
      start_attempt(16'h1234);
      chk("t1_entry_sv", start_verification, 1);
      send_sym(4'h1);
      send_sym(4'h2);
      chk("t1_idx2", digit_idx, 2);
      send_sym(4'h3);
      send_sym(4'h4);
      chk("t1_check_sv", start_verification, 1);
      chk("t1_check_done", done, 0);
      chk("t1_idx4", digit_idx, 4);
      step();
      chk("t1_done", done, 1);
      chk("t1_tries", tries_left, 3);
      next = 1'b1; step(); next = 1'b0;
      chk("t1_done_held", done, 1);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t1_wait", waiting_for_user, 1);
      chk("t1_done_low", done, 0);

      // 2: wrong last symbol, single-cycle fail
      start_attempt(16'h1234);
      send_sym(4'h1); send_sym(4'h2); send_sym(4'h3); send_sym(4'h5);
      chk("t2_check_fail0", fail, 0);
      step();
      chk("t2_fail", fail, 1);
      chk("t2_tries", tries_left, 2);
      step();
      chk("t2_fail_1cyc", fail, 0);
      chk("t2_wait", waiting_for_user, 1);

      // 3: two more wrong attempts -> LOCK for 16 cycles
      start_attempt(16'h1234);
      send_sym(4'h9); send_sym(4'h2); send_sym(4'h3); send_sym(4'h4);
      step();
      chk("t3_fail_a", fail, 1);
      chk("t3_tries_a", tries_left, 1);
      step();
      start_attempt(16'h1234);
      send_sym(4'h1); send_sym(4'h2); send_sym(4'h7); send_sym(4'h4);
      step();
      chk("t3_locked", locked, 1);
      chk("t3_fail_nolock", fail, 0);
      chk("t3_tries0", tries_left, 0);
      next = 1'b1; clear = 1'b1;
      n = 1;
      while (locked && n < 40) begin
         step();
         if (locked) n++;
      end
      next = 1'b0; clear = 1'b0;
      chk("t3_lock_cycles", n, 16);
      chk("t3_wait", waiting_for_user, 1);
      chk("t3_tries_reload", tries_left, 3);

      // 4: timeout after two symbols
      step();
      start_attempt(16'h1234);
      send_sym(4'h1); send_sym(4'h2);
      for (int i = 0; i < 5; i++) step();
      chk("t4_no_early_to", start_verification, 1);
      n = 5; seen = 1'b0;
      while (!seen && n < 30) begin
         step();
         n++;
         if (fail) seen = 1'b1;
      end
      chk("t4_fail_seen", seen, 1);
      chk("t4_fail_window", (n >= 9 && n <= 10), 1);
      chk("t4_tries", tries_left, 2);

      // 5: abort keeps tries; key change mid-entry has no effect
      step();
      start_attempt(16'h1234);
      send_sym(4'h1); send_sym(4'h2);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t5_wait", waiting_for_user, 1);
      chk("t5_tries", tries_left, 2);
      start_attempt(16'h1234);
      send_sym(4'h1);
      key = 16'h9999;
      send_sym(4'h2); send_sym(4'h3); send_sym(4'h4);
      step();
      chk("t5_old_key_done", done, 1);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t5_tries_reload", tries_left, 3);

      // 6: async reset mid-entry after consuming a try
      start_attempt(16'h1234);
      send_sym(4'h0); send_sym(4'h0); send_sym(4'h0); send_sym(4'h0);
      step(); step();
      chk("t6_tries_pre", tries_left, 2);
      start_attempt(16'h1234);
      send_sym(4'h1); send_sym(4'h2);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_wait", waiting_for_user, 1);
      chk("t6_rst_sv", start_verification, 0);
      chk("t6_rst_idx", digit_idx, 0);
      chk("t6_rst_tries", tries_left, 3);
      #2 rst_n = 1'b1;
      step();
      chk("t6_after_wait", waiting_for_user, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
